// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared widths, serializer state type and block byte-select helper
package des_pkg;

  localparam int BLOCK_W       = 64;
  localparam int BYTE_W        = 8;
  localparam int BYTES_PER_BLK = 8;
  localparam int IDX_W         = $clog2(BYTES_PER_BLK);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  // Byte 0 is the most significant byte of the block.
  function automatic logic [BYTE_W-1:0] blk_byte(input logic [BLOCK_W-1:0] blk,
                                                 input logic [IDX_W-1:0]   idx);
    logic [BLOCK_W-1:0] sh;
    sh = blk << {idx, 3'b000};
    return sh[BLOCK_W-1 -: BYTE_W];
  endfunction

endpackage

// File: rtl/des_blk_fifo.sv
// rtl/des_blk_fifo.sv - small FIFO of 64-bit cipher blocks with head-of-queue output
module des_blk_fifo
  import des_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push_i,
  input  logic [BLOCK_W-1:0]     data_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [BLOCK_W-1:0]     head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [BLOCK_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/des_out_serializer.sv
// rtl/des_out_serializer.sv - buffers DES cipher blocks and emits them MSB-first as a byte stream
// Optional byte parity output is enabled with macro DES_SER_PARITY_EN.
module des_out_serializer
  import des_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [BLOCK_W-1:0] blk_data,
  input  logic               blk_valid,
  input  logic               byte_ready,
  input  logic               ovf_clr,
  output logic [BYTE_W-1:0]  byte_out,
  output logic               byte_valid,
  output logic               byte_last,
  output logic               busy,
  output logic               overflow
`ifdef DES_SER_PARITY_EN
  ,
  output logic               byte_par
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_BLK - 1);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  ser_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ovf_q, ovf_d;

  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [BLOCK_W-1:0] head_blk;
  logic               xfer, pop, push, drop;

  assign xfer = byte_valid && byte_ready;
  assign pop  = xfer && (idx_q == LAST_IDX);
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign push = blk_valid && (!fifo_full || pop);
  assign drop = blk_valid && fifo_full && !pop;

  des_blk_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .data_i  (blk_data),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (head_blk)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (push) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (xfer) begin
          idx_d = idx_q + IDX_W'(1);
          if (pop && (fifo_count == ONE_C) && !push) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // A new overflow wins over a coincident clear.
  assign ovf_d = drop || (ovf_q && !ovf_clr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign byte_valid = (state_q == SEND);
  assign byte_out   = byte_valid ? blk_byte(head_blk, idx_q) : '0;
  assign byte_last  = byte_valid && (idx_q == LAST_IDX);
  assign busy       = !fifo_empty || byte_valid;
  assign overflow   = ovf_q;

`ifdef DES_SER_PARITY_EN
  assign byte_par = ^byte_out;
`endif

endmodule

// File: tb/tb_des_out_serializer.sv
// tb/tb_des_out_serializer.sv - randomized self-checking bench against a queue-based byte-stream model
module tb_des_out_serializer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] blk_data;
  logic        blk_valid, byte_ready, ovf_clr;
  logic [7:0]  byte_out;
  logic        byte_valid, byte_last, busy, overflow;
  logic        byte_par;

  always #5 clk = ~clk;

  des_out_serializer #(
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .blk_data   (blk_data),
    .blk_valid  (blk_valid),
    .byte_ready (byte_ready),
    .ovf_clr    (ovf_clr),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .busy       (busy),
    .overflow   (overflow)
`ifdef DES_SER_PARITY_EN
    ,
    .byte_par   (byte_par)
`endif
  );

`ifndef DES_SER_PARITY_EN
  assign byte_par = 1'b0;
`endif

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  // Model: a queue of buffered blocks; the head block is presented byte by byte.
  logic [63:0] blk_q[$];
  int          m_idx;
  bit          m_ovf;

  logic [7:0]  got_b[$];
  bit          got_l[$];
  bit          got_p[$];
  int          got_t[$];

  function automatic logic [12:0] dut_vec();
    return {byte_par, byte_out, byte_valid, byte_last, busy, overflow};
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [7:0] b;
    logic       v, p;
    v = (blk_q.size() != 0);
    b = v ? 8'(blk_q[0] >> (56 - 8 * m_idx)) : 8'h00;
`ifdef DES_SER_PARITY_EN
    p = ^b;
`else
    p = 1'b0;
`endif
    return {p, b, v, v && (m_idx == 7), v, m_ovf};
  endfunction

  task automatic model_reset();
    blk_q.delete();
    m_idx = 0;
    m_ovf = 0;
  endtask

  task automatic clear_got();
    got_b.delete();
    got_l.delete();
    got_p.delete();
    got_t.delete();
  endtask

  task automatic tick();
    bit xfer, pop, full;
    full = (blk_q.size() == DEPTH);
    xfer = (blk_q.size() != 0) && byte_ready;
    pop  = xfer && (m_idx == 7);
    if (byte_valid && byte_ready) begin
      got_b.push_back(byte_out);
      got_l.push_back(byte_last);
      got_p.push_back(byte_par);
      got_t.push_back(cyc);
    end
    @(posedge clk);
    if (xfer) begin
      if (m_idx == 7) begin
        void'(blk_q.pop_front());
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
    if (blk_valid) begin
      if (!full || pop) blk_q.push_back(blk_data);
      else m_ovf = 1;
    end
    if (ovf_clr && !(blk_valid && full && !pop)) m_ovf = 0;
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; blk_data = '0; blk_valid = 0; byte_ready = 0; ovf_clr = 0;
    model_reset();
    @(negedge clk);
    vectors++;
    if (dut_vec() !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec(), 13'd0);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_single_block();
    logic [7:0] exp_b [8] = '{8'h85, 8'hE8, 8'h13, 8'h54, 8'h0F, 8'h0A, 8'hB4, 8'h05};
    int t_push;
    clear_got();
    blk_data = 64'h85E813540F0AB405; blk_valid = 1; byte_ready = 1;
    t_push = cyc;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk); vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL single cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
      blk_valid = 0;
    end
    vectors++;
    if (got_b.size() != 8) begin
      miscompares++;
      $display("FAIL single_count got=%0d exp=8", got_b.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (got_b[i] !== exp_b[i] || got_l[i] !== (i == 7) || got_t[i] !== t_push + 1 + i
            || got_p[i] !== (^exp_b[i]) && got_p[i] !== 1'b0 && 1'b0) begin
          miscompares++;
          $display("FAIL single_byte%0d got=%h/%0d@%0d exp=%h/%0d@%0d", i, got_b[i], got_l[i],
                   got_t[i], exp_b[i], (i == 7), t_push + 1 + i);
        end
`ifdef DES_SER_PARITY_EN
        vectors++;
        if (got_p[i] !== (^exp_b[i])) begin
          miscompares++;
          $display("FAIL single_par%0d got=%0d exp=%0d", i, got_p[i], ^exp_b[i]);
        end
`endif
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_busy_after got=%0d exp=0", busy);
    end
  endtask

  task automatic test_stall();
    logic [63:0] blk = 64'h85E813540F0AB405;
    logic [12:0] prev;
    bit          prev_stall = 0;
    clear_got();
    blk_data = blk; blk_valid = 1;
    for (int k = 0; k < 30; k++) begin
      byte_ready = (k % 3 == 0);
      @(negedge clk); vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL stall cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (prev_stall) begin
        vectors++;
        if (dut_vec() !== prev) begin
          miscompares++;
          $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, dut_vec(), prev);
        end
      end
      prev       = dut_vec();
      prev_stall = byte_valid && !byte_ready;
      tick();
      blk_valid = 0;
    end
    vectors++;
    if (got_b.size() != 8) begin
      miscompares++;
      $display("FAIL stall_count got=%0d exp=8", got_b.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (got_b[i] !== 8'(blk >> (56 - 8 * i)) || got_l[i] !== (i == 7)) begin
          miscompares++;
          $display("FAIL stall_byte%0d got=%h exp=%h", i, got_b[i], 8'(blk >> (56 - 8 * i)));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a = 64'h0123456789ABCDEF;
    logic [63:0] b = 64'hFEDCBA9876543210;
    logic [7:0]  e;
    clear_got();
    byte_ready = 1;
    for (int k = 0; k < 22; k++) begin
      blk_valid = (k == 0) || (k == 2);
      blk_data  = (k == 0) ? a : b;
      @(negedge clk); vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
    blk_valid = 0;
    vectors++;
    if (got_b.size() != 16) begin
      miscompares++;
      $display("FAIL b2b_count got=%0d exp=16", got_b.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        e = (i < 8) ? 8'(a >> (56 - 8 * i)) : 8'(b >> (56 - 8 * (i - 8)));
        vectors++;
        if (got_b[i] !== e || got_t[i] !== got_t[0] + i) begin
          miscompares++;
          $display("FAIL b2b_byte%0d got=%h@%0d exp=%h@%0d", i, got_b[i], got_t[i], e, got_t[0] + i);
        end
      end
    end
  endtask

  task automatic test_overflow();
    bit done = 0;
    byte_ready = 0;
    for (int k = 0; k < 6; k++) begin
      blk_valid = (k < 3);
      blk_data  = {$urandom, $urandom};
      @(negedge clk); vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL ovf_fill cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
    blk_valid = 0;
    @(negedge clk); vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set got=%0d exp=1", overflow);
    end
    ovf_clr = 1; tick(); ovf_clr = 0;
    @(negedge clk); vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear got=%0d exp=0", overflow);
    end
    blk_valid = 1; ovf_clr = 1; blk_data = {$urandom, $urandom};
    tick();
    blk_valid = 0; ovf_clr = 0;
    @(negedge clk); vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_clr_vs_new got=%0d exp=1", overflow);
    end
    ovf_clr = 1; tick(); ovf_clr = 0;
    clear_got();
    byte_ready = 1;
    for (int k = 0; k < 40; k++) begin
      blk_valid = !done && (m_idx == 7) && (blk_q.size() == DEPTH);
      blk_data  = {$urandom, $urandom};
      if (blk_valid) done = 1;
      @(negedge clk); vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL ovf_pop_push cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
    blk_valid = 0;
    vectors++;
    if (!done || got_b.size() != 24 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_full_pop_accept got=%0d bytes ovf=%0d hit=%0d exp=24 bytes ovf=0 hit=1",
               got_b.size(), overflow, done);
    end
  endtask

  task automatic test_reset_mid();
    clear_got();
    byte_ready = 1; blk_valid = 1; blk_data = 64'h0011223344556677;
    for (int k = 0; k < 20 && got_b.size() < 3; k++) begin
      @(negedge clk); vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL rst_mid_pre cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
      blk_valid = (k == 0);
    end
    blk_valid = 1;
    vectors++;
    if (got_b.size() != 3) begin
      miscompares++;
      $display("FAIL rst_mid_reach got=%0d exp=3", got_b.size());
    end
    #2 rstn = 1'b0;
    #1 vectors++;
    if (dut_vec() !== 13'd0) begin
      miscompares++;
      $display("FAIL rst_mid_async got=%h exp=%h", dut_vec(), 13'd0);
    end
    model_reset();
    blk_valid = 0;
    @(posedge clk); #1 rstn = 1'b1;
    for (int k = 0; k < 16; k++) begin
      blk_valid = (k == 6);
      blk_data  = 64'hA5A5_0F0F_3C3C_9696;
      @(negedge clk); vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL rst_mid_post cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
    blk_valid = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      blk_valid  = ($urandom % 4 == 0);
      blk_data   = {$urandom, $urandom};
      byte_ready = ($urandom % 4 != 0);
      ovf_clr    = ($urandom % 16 == 0);
      @(negedge clk); vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
    blk_valid = 0; ovf_clr = 0; byte_ready = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
